fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage feeding the decoder that drives the register file's `rs1`/`rs2`/`rd`, `reg_write`, `label_read` and `branch_i` controls. It owns the program counter and issues one request at a time to instruction memory over a req/ack handshake. It holds each fetched instruction stable until decode accepts it. On acceptance it applies the branch or halt decision that decode and the register-file compare produce.

## Interface
Parameters:
- `PC_W`, 8, program-counter and instruction-memory address width.
- `INSN_W`, 9, instruction width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle pulse; begins fetching at address 0.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  PC_W  fetch address; equals `pc_o` while `imem_req`=1.
- `imem_ack`  in  1  memory has `imem_data` valid this cycle.
- `imem_data`  in  INSN_W  fetched instruction.
- `instr_o`  out  INSN_W  instruction presented to decode.
- `instr_valid_o`  out  1  `instr_o` is valid.
- `decode_ready_i`  in  1  decode accepts `instr_o` this cycle.
- `branch_i`  in  1  accepted instruction is a branch.
- `branch_taken_i`  in  1  branch condition true.
- `branch_target_i`  in  PC_W  redirect address.
- `halt_i`  in  1  accepted instruction is a halt.
- `pc_o`  out  PC_W  current program counter.
- `halted_o`  out  1  fetch stopped by halt.
- `icount_o`  out  16  accepted-instruction count (see Configuration).

## Operation
- Reset state: IDLE. Reset values: `pc_o`=0, `imem_req`=0, `instr_valid_o`=0, `instr_o`=0, `halted_o`=0, `icount_o`=0.
- States: IDLE, REQ, HOLD, HALT. All outputs are registered.
- IDLE:
  - `start`=1: `pc_o`←0, go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - `imem_req`=1 and `imem_addr`=`pc_o`; both held stable until ack.
  - `imem_ack`=1: `instr_o`←`imem_data`, `instr_valid_o`←1, `pc_o`←`pc_o`+1 modulo 2^PC_W (0xFF wraps to 0x00), `imem_req`←0, go to HOLD.
- HOLD:
  - `instr_o` and `instr_valid_o` stay stable until the accept cycle (`instr_valid_o`=1 and `decode_ready_i`=1).
  - `branch_i`, `branch_taken_i`, `branch_target_i` and `halt_i` are sampled only in the accept cycle.
  - Accept cycle: `instr_valid_o`←0.
    - `halt_i`=1: go to HALT, `halted_o`←1. Halt has priority over branch.
    - Else `branch_i`=1 and `branch_taken_i`=1: `pc_o`←`branch_target_i`, go to REQ.
    - Else go to REQ with the already-incremented `pc_o`.
- HALT:
  - `imem_req`=0 and `halted_o`=1.
  - `start`=1: `halted_o`←0, `pc_o`←0, go to REQ.
- `imem_ack` is ignored outside REQ.
- `start` is ignored in REQ and HOLD.
- `reset` has priority over everything. Asserted mid-request, `imem_req` drops at that same edge, and a late `imem_ack` is ignored.

## Timing
- `start` at cycle 0: `imem_req`=1 from cycle 1.
- Ack in cycle n: `instr_valid_o`=1 from cycle n+1.
- Accept in cycle m: next `imem_req` from cycle m+1, addressing the updated PC.
- Best-case throughput: one instruction per 2 cycles (zero-wait memory, decode always ready).
- Redirect penalty: none beyond the base 2 cycles; the target address is on `imem_addr` the cycle after accept.

## Configuration
- `FETCH_ICOUNT_EN` defined:
  - `icount_o` is a 16-bit counter that increments by 1 in every accept cycle and wraps from 0xFFFF to 0.
  - It clears on `reset` and on an accepted `start`.
- `FETCH_ICOUNT_EN` undefined: no counter is built and `icount_o` is tied to 0.

## Test plan
- Reset, `start`, memory always acks, decode always ready, ROM[0..3]=0x001,0x0A2,0x1FF,0x055 → `imem_addr` 0,1,2,3; `instr_o` follows the ROM in order; `instr_valid_o` alternates 1/0.
- Memory acks 3 cycles after each req; decode ready held low 4 cycles → `imem_addr` and `instr_o` stable throughout both waits; no duplicated or dropped instruction.
- Instruction at address 2 accepted with `branch_i`=1, `branch_taken_i`=1, `branch_target_i`=0x10 → next `imem_addr`=0x10. Same case with `branch_taken_i`=0 → next `imem_addr`=0x03.
- `halt_i`=1 and a taken branch in the same accept cycle → HALT entered, `halted_o`=1, `imem_req` stays 0. Later `start` → fetch resumes at 0 and `halted_o`=0.
- PC at 0xFF, non-branch accepted → next `imem_addr`=0x00. `reset` pulsed while `imem_req`=1 → `imem_req`=0 next cycle, a following ack is ignored, state is IDLE.
- With `FETCH_ICOUNT_EN` defined: 5 accepts → `icount_o`=5; `start` from HALT → `icount_o`=0. Without the macro: `icount_o`=0 throughout.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, one outstanding imem request, holds the instruction until decode accepts it.
// Optional accepted-instruction counter enabled by defining FETCH_ICOUNT_EN.
module fetch_unit #(
    parameter int PC_W   = 8,
    parameter int INSN_W = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [INSN_W-1:0] imem_data,
    output logic [INSN_W-1:0] instr_o,
    output logic              instr_valid_o,
    input  logic              decode_ready_i,
    input  logic              branch_i,
    input  logic              branch_taken_i,
    input  logic [PC_W-1:0]   branch_target_i,
    input  logic              halt_i,
    output logic [PC_W-1:0]   pc_o,
    output logic              halted_o,
    output logic [15:0]       icount_o
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, HALT} state_t;

    state_t              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [INSN_W-1:0]   instr_q, instr_d;
    logic                req_q, req_d;
    logic                valid_q, valid_d;
    logic                halted_q, halted_d;
    logic                accept;
    logic                start_acc;

    assign accept    = (state_q == HOLD) && valid_q && decode_ready_i;
    assign start_acc = start && ((state_q == IDLE) || (state_q == HALT));

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        req_d    = req_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    pc_d    = '0;
                    req_d   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (imem_ack) begin
                    instr_d = imem_data;
                    valid_d = 1'b1;
                    pc_d    = pc_q + PC_W'(1);
                    req_d   = 1'b0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (accept) begin
                    valid_d = 1'b0;
                    // halt wins over a taken branch in the same accept cycle
                    if (halt_i) begin
                        halted_d = 1'b1;
                        state_d  = HALT;
                    end else begin
                        req_d   = 1'b1;
                        state_d = REQ;
                        if (branch_i && branch_taken_i)
                            pc_d = branch_target_i;
                    end
                end
            end
            HALT: begin
                if (start) begin
                    halted_d = 1'b0;
                    pc_d     = '0;
                    req_d    = 1'b1;
                    state_d  = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            instr_q  <= '0;
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            req_q    <= req_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    assign imem_req      = req_q;
    assign imem_addr     = pc_q;
    assign pc_o          = pc_q;
    assign instr_o       = instr_q;
    assign instr_valid_o = valid_q;
    assign halted_o      = halted_q;

`ifdef FETCH_ICOUNT_EN
    logic [15:0] icount_q, icount_d;

    always_comb begin
        icount_d = icount_q;
        if (start_acc)
            icount_d = '0;
        else if (accept)
            icount_d = icount_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            icount_q <= '0;
        else
            icount_q <= icount_d;
    end

    assign icount_o = icount_q;
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
    assign icount_o = '0;
`endif

endmodule
